// File: rtl/pulse_spacer_if.sv
// Handshake bundle for pulse_spacer: event/clear inputs and spaced-pulse status outputs.
// The testbench or upstream logic drives through master; the spacer attaches to slave.
interface pulse_spacer_if #(
  parameter int CNT_W = 4
);
  logic             i_clr;
  logic             i_evt;
  logic             o_pulse;
  logic [CNT_W-1:0] o_pending;
  logic             o_full;
  logic             o_overflow;
  logic             o_busy;

  modport master (
    output i_clr,
    output i_evt,
    input  o_pulse,
    input  o_pending,
    input  o_full,
    input  o_overflow,
    input  o_busy
  );

  modport slave (
    input  i_clr,
    input  i_evt,
    output o_pulse,
    output o_pending,
    output o_full,
    output o_overflow,
    output o_busy
  );
endinterface

// File: rtl/pulse_spacer.sv
// Rate limiter ahead of a toggle pulse synchronizer: queues event strobes and re-emits
// them as single-cycle pulses at least GAP cycles apart, flagging dropped events.
module pulse_spacer #(
  parameter int GAP   = 3,
  parameter int CNT_W = 4
) (
  input logic          i_clk,
  input logic          i_rst_n,
  pulse_spacer_if.slave bus
);

  localparam int               TMR_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] MAX    = '1;
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLDOFF,
    ST_READY
  } state_e;

  logic             pulse_q,    pulse_d;
  logic [CNT_W-1:0] pending_q,  pending_d;
  logic [TMR_W-1:0] timer_q,    timer_d;
  logic             overflow_q, overflow_d;

  state_e state;
  logic   emit;
  logic   accept;

  // The state is a view of counter and timer, so it needs no register of its own.
  always_comb begin
    if (timer_q != '0) begin
      state = ST_HOLDOFF;
    end else if (pending_q != '0) begin
      state = ST_READY;
    end else begin
      state = ST_IDLE;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    emit       = (state == ST_READY) || ((state == ST_IDLE) && bus.i_evt);
    accept     = bus.i_evt && ((pending_q != MAX) || emit);
    pulse_d    = emit;
    pending_d  = pending_q;
    timer_d    = timer_q;
    overflow_d = overflow_q;

    if (emit) begin
      timer_d = RELOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TMR_W'(1);
    end

    // Accept plus emit in one cycle is a net zero, which also covers the idle bypass.
    if (accept && !emit) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (emit && !accept) begin
      pending_d = pending_q - CNT_W'(1);
    end

    if (bus.i_evt && !accept) begin
      overflow_d = 1'b1;
    end

    if (bus.i_clr) begin
      pulse_d    = 1'b0;
      pending_d  = '0;
      timer_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pulse_q    <= 1'b0;
      pending_q  <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pulse_q    <= pulse_d;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.o_pulse    = pulse_q;
  assign bus.o_pending  = pending_q;
  assign bus.o_full     = (pending_q == MAX);
  assign bus.o_overflow = overflow_q;
  assign bus.o_busy     = (pending_q != '0) || (timer_q != '0);

endmodule

// File: doc/pulse_spacer.md
Name: pulse_spacer

Overview:
Source-domain rate limiter that sits directly upstream of the toggle-based pulse synchronizer. It accepts single-cycle event strobes at up to one per i_clk cycle and counts the ones not yet issued. It re-emits them as single-cycle pulses spaced at least GAP cycles apart, so the downstream toggle synchronizer never merges or drops events. Excess events beyond counter capacity are dropped and flagged by a sticky overflow bit.

Parameters:
GAP, 3, minimum spacing in i_clk cycles between consecutive o_pulse assertions (>=1; integrator sets GAP >= 2*ceil(f_i_clk/f_o_clk)+1)
CNT_W, 4, pending-event counter width; capacity MAX = 2^CNT_W-1

Ports:
i_clk  input  1  source-domain clock
i_rst_n  input  1  asynchronous active-low reset
i_clr  input  1  synchronous clear of pending count, holdoff timer, overflow and o_pulse
i_evt  input  1  event strobe, one event per high cycle
o_pulse  output  1  spaced single-cycle pulse, registered; feeds the synchronizer's i_pulse
o_pending  output  CNT_W  events accepted but not yet issued
o_full  output  1  o_pending == MAX
o_overflow  output  1  sticky, event dropped since last reset/clear
o_busy  output  1  o_pending != 0 or holdoff timer != 0

Behaviour:
- Clock i_clk; reset i_rst_n, asynchronous, active-low. Reset values: o_pulse=0, o_pending=0, holdoff timer=0, o_overflow=0; hence o_full=0, o_busy=0.
- Holdoff timer, width clog2(GAP) (min 1):
  - loaded with GAP-1 on the edge where o_pulse is set;
  - otherwise decrements while non-zero.
  - gap_ok = (timer == 0).
- emit = gap_ok && (o_pending != 0 || i_evt). o_pulse <= emit.
- Latency: with the block idle (pending 0, timer 0), i_evt in cycle t gives o_pulse in cycle t+1. The event bypasses the counter and o_pending stays 0.
- Spacing: o_pulse in cycle t means the next o_pulse occurs no earlier than t+GAP. With GAP=1, back-to-back pulses are allowed.
- Counter update: accept = i_evt && (o_pending != MAX || emit).
  - o_pending_next = o_pending + accept - emit.
  - Simultaneous accept and emit leaves the count unchanged.
  - The counter never wraps.
- Full: i_evt while o_pending == MAX and no emit drops the event. o_pending holds MAX and o_overflow is set. If emit occurs the same cycle, the event is accepted and the count holds at MAX.
- o_overflow stays set until reset or i_clr.
- i_clr has priority over all other updates. Next cycle: o_pulse=0, o_pending=0, timer=0, o_overflow=0. An i_evt in the same cycle as i_clr is discarded.
- State view:
  - IDLE (pending 0, timer 0);
  - HOLDOFF (timer != 0);
  - READY (timer 0, pending != 0, emits this cycle).
  - Transitions are implied by the counter and timer rules above. No other states.
- Asynchronous reset mid-holdoff or with events pending discards all pending events. No pulse is emitted on reset release.
- o_full, o_busy: combinational from the registered state, no extra latency.

Test Plan:
- Single event: GAP=3, idle, i_evt high at cycle 0 -> o_pulse high only in cycle 1, o_pending stays 0, o_busy high cycles 1-2, low from cycle 3.
- Burst: GAP=3, i_evt high cycles 0-4 -> o_pulse in cycles 1,4,7,10,13 exactly. o_pending peaks at 3 after cycle 4, reaches 0 after cycle 12. o_overflow=0.
- Overflow: CNT_W=2, GAP=8, i_evt high cycles 0-5 -> pulses at 1 and 9. Pending reaches 3 (o_full=1) after cycle 3. Events at cycles 4-5 are dropped and o_overflow set from cycle 5. Total 4 pulses, then pending 0 with o_overflow still 1.
- Full plus simultaneous emit: CNT_W=2, pending=3, i_evt coincides with the emit cycle -> o_pulse next cycle, o_pending stays 3, o_overflow unchanged 0.
- Clear mid-burst: pending=2 and timer non-zero, i_clr and i_evt high together -> next cycle o_pending=0, o_overflow=0, o_busy=0, and no further o_pulse.
- Async reset mid-holdoff: assert i_rst_n=0 between clock edges with pending=3 -> outputs zero immediately. After release with i_evt low, no o_pulse for 20 cycles.
